// File: rtl/hc_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read-request channel among N_REQ requestors,
// with mdata tagging, per-requestor read credits and response routing. Optional: HC_RD_ARB_STATS_EN.
package hc_ccip_pkg;
    localparam logic [31:0] HC_CONTROL_START = 32'h0000_0001;
    localparam logic [3:0]  eREQ_RDLINE_I    = 4'h0;
    localparam logic [3:0]  eRSP_RDLINE      = 4'h0;
    localparam logic [3:0]  eRSP_UMSG        = 4'h4;

    typedef logic [511:0] t_ccip_clData;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;
endpackage

// Per-requestor outstanding-read credit counter (8 bit, never wraps below zero).
module hc_rd_arb_credit #(
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_avail,
    output logic o_zero,
    output logic o_underflow
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    logic [7:0] r_cnt;
    logic       w_dec_ok;

    assign w_dec_ok    = i_dec && (r_cnt != 8'd0);
    assign o_avail     = r_cnt < MAX_CNT;
    assign o_zero      = r_cnt == 8'd0;
    assign o_underflow = i_dec && (r_cnt == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else begin
            case ({i_inc, w_dec_ok})
                2'b10:   r_cnt <= r_cnt + 8'd1;
                2'b01:   r_cnt <= r_cnt - 8'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module hc_rd_arbiter
    import hc_ccip_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [31:0]                         hc_control,
    input  t_if_ccip_Rx                         ccip_rx,
    input  logic [N_REQ-1:0]                    req_valid,
    input  t_ccip_c0_ReqMemHdr [N_REQ-1:0]      req_hdr,
    output logic [N_REQ-1:0]                    req_grant,
    output t_if_ccip_c0_Tx                      ccip_c0_tx,
    output logic [N_REQ-1:0]                    rsp_valid,
    output t_ccip_c0_RspMemHdr                  rsp_hdr,
    output t_ccip_clData                        rsp_data,
    output logic                                drained,
    output logic                                err
`ifdef HC_RD_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0]              stat_grants,
    output logic [31:0]                         stat_stalls
`endif
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_RUN, S_ARB_DRAIN} t_arb_state;

    t_arb_state         r_state;
    logic [IW-1:0]      r_ptr;
    t_if_ccip_c0_Tx     r_tx;
    logic [N_REQ-1:0]   r_rsp_valid;
    t_ccip_c0_RspMemHdr r_rsp_hdr;
    t_ccip_clData       r_rsp_data;
    logic               r_drained;
    logic               r_err;

    logic               w_start;
    logic [N_REQ-1:0]   w_avail, w_zero, w_underflow, w_elig, w_grant, w_dec;
    logic               w_found;
    logic [IW-1:0]      w_grant_idx, w_ptr_next;
    logic [IW:0]        w_sum;
    t_ccip_c0_ReqMemHdr w_tx_hdr;
    logic               w_rsp_rd, w_tag_ok, w_all_zero;
    logic [3:0]         w_tag;
    logic               w_unused;

    assign w_start    = hc_control == HC_CONTROL_START;
    assign w_rsp_rd   = ccip_rx.c0.rspValid && (ccip_rx.c0.hdr.resp_type == eRSP_RDLINE);
    assign w_tag      = ccip_rx.c0.hdr.mdata[3:0];
    assign w_tag_ok   = {1'b0, w_tag} < 5'(N_REQ);
    assign w_all_zero = &w_zero;
    assign w_unused   = ^{ccip_rx, req_hdr};

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_lane
            assign w_elig[g] = (r_state == S_ARB_RUN) && req_valid[g] && w_avail[g] &&
                               !ccip_rx.c0TxAlmFull;
            assign w_dec[g]  = w_rsp_rd && w_tag_ok && (w_tag == 4'(g));

            hc_rd_arb_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
                .clk         (clk),
                .reset       (reset),
                .i_inc       (w_grant[g]),
                .i_dec       (w_dec[g]),
                .o_avail     (w_avail[g]),
                .o_zero      (w_zero[g]),
                .o_underflow (w_underflow[g])
            );
        end
    endgenerate

    // First eligible requestor at or after the RR pointer, wrapping at N_REQ.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N_REQ))
                w_sum = w_sum - (IW+1)'(N_REQ);
            if (!w_found && w_elig[w_sum[IW-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_sum[IW-1:0];
            end
        end
        w_grant = '0;
        if (w_found)
            w_grant[w_grant_idx] = 1'b1;
        w_ptr_next = (w_grant_idx == IW'(N_REQ-1)) ? '0 : w_grant_idx + IW'(1);
        w_tx_hdr            = req_hdr[w_grant_idx];
        w_tx_hdr.mdata[3:0] = 4'(w_grant_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_ARB_IDLE;
            r_ptr       <= '0;
            r_tx        <= '0;
            r_rsp_valid <= '0;
            r_rsp_hdr   <= '0;
            r_rsp_data  <= '0;
            r_drained   <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_ARB_IDLE:  if (w_start) r_state <= S_ARB_RUN;
                S_ARB_RUN:   if (!w_start) r_state <= S_ARB_DRAIN;
                S_ARB_DRAIN: begin
                    if (w_start)         r_state <= S_ARB_RUN;
                    else if (w_all_zero) r_state <= S_ARB_IDLE;
                end
                default:     r_state <= S_ARB_IDLE;
            endcase
            if (w_found) begin
                r_ptr      <= w_ptr_next;
                r_tx.hdr   <= w_tx_hdr;
            end
            r_tx.valid  <= w_found;
            // Underflowing responses are still delivered; only out-of-range tags are dropped.
            r_rsp_valid <= w_dec;
            if (|w_dec) begin
                r_rsp_hdr  <= ccip_rx.c0.hdr;
                r_rsp_data <= ccip_rx.c0.data;
            end
            r_drained <= (r_state == S_ARB_IDLE) && w_all_zero;
            r_err     <= r_err | (w_rsp_rd && !w_tag_ok) | (|w_underflow);
        end
    end

    assign req_grant  = w_grant;
    assign ccip_c0_tx = r_tx;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_hdr    = r_rsp_hdr;
    assign rsp_data   = r_rsp_data;
    assign drained    = r_drained;
    assign err        = r_err;

`ifdef HC_RD_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] r_stat_grants;
    logic [31:0]            r_stat_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_grants <= '0;
            r_stat_stalls <= '0;
        end else if ((r_state == S_ARB_IDLE) && w_start) begin
            r_stat_grants <= '0;
            r_stat_stalls <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (w_grant[i]) r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
            if ((r_state == S_ARB_RUN) && (|req_valid) && !w_found)
                r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_stalls = r_stat_stalls;
`endif
endmodule
